// File: rtl/note_sequencer.sv
// note_sequencer: steps through one song held in an external synchronous song
// ROM and hands each note to the note player. Each note is held for the number
// of beats encoded with it.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   play       1 = run, 0 = pause (level)
//   song       song select, latched only when leaving IDLE
//   beat       one-cycle beat pulse from the beat generator
//   rom_addr   song ROM address {song_q, idx}
//   rom_data   ROM word {note, duration}, valid one cycle after rom_addr
//   note       current note (0 = rest)
//   duration   duration of the current note in beats
//   new_note   one-cycle pulse in the first PLAY cycle of each note
//   playing    high while in PLAY with play=1
//   song_done  high while in DONE
module note_sequencer #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5,
  parameter int SONG_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic [SONG_W-1:0]         song,
  input  logic                      beat,
  output logic [SONG_W+IDX_W-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      new_note,
  output logic                      playing,
  output logic                      song_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_PLAY, S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [SONG_W-1:0]   r_song_q;
  logic [DUR_W-1:0]    r_beat_cnt;
  logic [NOTE_W-1:0]   r_note;
  logic [DUR_W-1:0]    r_dur;
  logic                r_new_note;

  logic [NOTE_W-1:0]   w_rom_note;
  logic [DUR_W-1:0]    w_rom_dur;
  logic                w_end_mark;
  logic                w_step;
  logic                w_last_beat;

  assign w_rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur   = rom_data[DUR_W-1:0];
  // A zero duration can never be played, so it doubles as end-of-song.
  assign w_end_mark  = (w_rom_dur == '0);
  // Beats only count while actually playing; paused or fetching they are lost.
  assign w_step      = (r_state == S_PLAY) && play && beat;
  assign w_last_beat = w_step && ((r_beat_cnt + 1'b1) == r_dur);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (play) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = w_end_mark ? S_DONE : S_PLAY;
      S_PLAY:   if (w_last_beat) w_state_nxt = (r_idx == LAST_IDX) ? S_DONE : S_FETCH;
      S_DONE:   if (!play) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_song_q   <= '0;
      r_beat_cnt <= '0;
      r_note     <= '0;
      r_dur      <= '0;
      r_new_note <= 1'b0;
    end else begin
      r_new_note <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (play) begin
            r_song_q <= song;
            r_idx    <= '0;
          end
        end
        S_DECODE: begin
          if (!w_end_mark) begin
            r_note     <= w_rom_note;
            r_dur      <= w_rom_dur;
            r_beat_cnt <= '0;
            r_new_note <= 1'b1;
          end
        end
        S_PLAY: begin
          if (w_step) begin
            if (w_last_beat) begin
              // Last entry ends the song instead of wrapping to idx 0.
              if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_note <= '0;
          if (!play) r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rom_addr  = {r_song_q, r_idx};
  assign note      = r_note;
  assign duration  = r_dur;
  assign new_note  = r_new_note;
  assign playing   = (r_state == S_PLAY) && play;
  assign song_done = (r_state == S_DONE);

endmodule
